// File: rtl/ahci_fis_dispatch_if.sv
// Engine-side handshake between the FIS dispatch sequencer and the FIS
// receive engine: FIFO head status, engine completion flags, get_* requests.
//   master : dispatcher (drives get_* requests, observes engine status)
//   slave  : receive engine (drives status, observes get_* requests)
interface ahci_fis_dispatch_if;
    logic       fis_first_vld;
    logic [7:0] fis_type;
    logic       get_fis_busy;
    logic       fis_ok;
    logic       fis_err;
    logic       fis_ferr;

    logic       get_sig;
    logic       get_dsfis;
    logic       get_psfis;
    logic       get_rfis;
    logic       get_sdbfis;
    logic       get_ufis;
    logic       get_data_fis;
    logic       get_ignore;

    modport master (
        input  fis_first_vld, fis_type, get_fis_busy,
        input  fis_ok, fis_err, fis_ferr,
        output get_sig, get_dsfis, get_psfis, get_rfis,
        output get_sdbfis, get_ufis, get_data_fis, get_ignore
    );

    modport slave (
        output fis_first_vld, fis_type, get_fis_busy,
        output fis_ok, fis_err, fis_ferr,
        input  get_sig, get_dsfis, get_psfis, get_rfis,
        input  get_sdbfis, get_ufis, get_data_fis, get_ignore
    );
endinterface

// File: rtl/ahci_fis_dispatch.sv
// FIS dispatch sequencer in front of the FIS receive engine.
// Ports: mclk/hba_rst_n (clock, async active-low reset); eng (engine
// handshake, master side); fis_rx_en/sig_pending (config, sampled in ISSUE);
// done_* / fis_crc_err / fis_timeout (registered one-cycle event pulses);
// fatal (sticky), busy (state != IDLE), fis_count/err_count (saturating).
module ahci_fis_dispatch #(
    parameter int TIMEOUT_BITS = 16
) (
    input  logic        mclk,
    input  logic        hba_rst_n,
    ahci_fis_dispatch_if.master eng,
    input  logic        fis_rx_en,
    input  logic        sig_pending,
    output logic        done_d2h,
    output logic        done_sdb,
    output logic        done_ds,
    output logic        done_ps,
    output logic        done_sig,
    output logic        done_data,
    output logic        done_dma_act,
    output logic        fis_crc_err,
    output logic        fis_timeout,
    output logic        fatal,
    output logic        busy,
    output logic [15:0] fis_count,
    output logic [7:0]  err_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FATAL = 2'd3;

    localparam logic [7:0] T_D2H  = 8'h34;
    localparam logic [7:0] T_SDB  = 8'hA1;
    localparam logic [7:0] T_DS   = 8'h41;
    localparam logic [7:0] T_PS   = 8'h5F;
    localparam logic [7:0] T_DATA = 8'h46;
    localparam logic [7:0] T_DMA  = 8'h39;

    // done vector bit positions
    localparam int D_D2H  = 6;
    localparam int D_SDB  = 5;
    localparam int D_DS   = 4;
    localparam int D_PS   = 3;
    localparam int D_SIG  = 2;
    localparam int D_DATA = 1;
    localparam int D_DMA  = 0;

    localparam logic [TIMEOUT_BITS-1:0] WD_ONE = 1;

    logic [1:0]              state_q, state_d;
    logic [7:0]              type_q, type_d;
    logic                    sig_q, sig_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
    logic                    fatal_q, fatal_d;
    logic [15:0]             fis_cnt_q, fis_cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [6:0]              done_q, done_d;
    logic                    crc_q, crc_d;
    logic                    to_q, to_d;

    logic wd_first;
    logic wd_expire;
    logic complete;

    // The watchdog is cleared in ISSUE, so a zero count marks the first
    // WAIT cycle, where the engine busy flag is only just rising.
    assign wd_first  = (wd_q == '0);
    // Expiry when this WAIT cycle's increment reaches all-ones.
    assign wd_expire = (wd_q == ~WD_ONE);
    assign complete  = !wd_first && !eng.get_fis_busy;

    // Request decode: live config is only looked at while in ISSUE.
    always_comb begin
        eng.get_sig      = 1'b0;
        eng.get_dsfis    = 1'b0;
        eng.get_psfis    = 1'b0;
        eng.get_rfis     = 1'b0;
        eng.get_sdbfis   = 1'b0;
        eng.get_ufis     = 1'b0;
        eng.get_data_fis = 1'b0;
        eng.get_ignore   = 1'b0;
        if (state_q == S_ISSUE) begin
            case (type_q)
                T_D2H: begin
                    if (sig_pending)
                        eng.get_sig = 1'b1;
                    else if (fis_rx_en)
                        eng.get_rfis = 1'b1;
                    else
                        eng.get_ignore = 1'b1;
                end
                T_SDB: begin
                    eng.get_sdbfis = fis_rx_en;
                    eng.get_ignore = !fis_rx_en;
                end
                T_DS: begin
                    eng.get_dsfis  = fis_rx_en;
                    eng.get_ignore = !fis_rx_en;
                end
                T_PS: begin
                    eng.get_psfis  = fis_rx_en;
                    eng.get_ignore = !fis_rx_en;
                end
                T_DATA: eng.get_data_fis = 1'b1;
                T_DMA:  eng.get_ignore   = 1'b1;
                default: begin
                    eng.get_ufis   = fis_rx_en;
                    eng.get_ignore = !fis_rx_en;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        sig_d     = sig_q;
        wd_d      = wd_q;
        fatal_d   = fatal_q;
        fis_cnt_d = fis_cnt_q;
        err_cnt_d = err_cnt_q;
        done_d    = '0;
        crc_d     = 1'b0;
        to_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (eng.fis_first_vld && !fatal_q) begin
                    type_d  = eng.fis_type;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                // Remember whether this D2H went out as a signature FIS.
                sig_d   = sig_pending && (type_q == T_D2H);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_ONE;
                if (eng.fis_ferr) begin
                    fatal_d = 1'b1;
                    state_d = S_FATAL;
                end else if (complete) begin
                    state_d = S_IDLE;
                    if (eng.fis_ok) begin
                        if (fis_cnt_q != '1)
                            fis_cnt_d = fis_cnt_q + 16'd1;
                        case (type_q)
                            T_D2H: begin
                                if (sig_q)
                                    done_d[D_SIG] = 1'b1;
                                else
                                    done_d[D_D2H] = 1'b1;
                            end
                            T_SDB:  done_d[D_SDB]  = 1'b1;
                            T_DS:   done_d[D_DS]   = 1'b1;
                            T_PS:   done_d[D_PS]   = 1'b1;
                            T_DATA: done_d[D_DATA] = 1'b1;
                            T_DMA:  done_d[D_DMA]  = 1'b1;
                            default: ;
                        endcase
                    end else if (eng.fis_err) begin
                        crc_d = 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else if (wd_expire) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                    if (err_cnt_q != '1)
                        err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            S_FATAL: ;
        endcase
    end

    always_ff @(posedge mclk or negedge hba_rst_n) begin
        if (!hba_rst_n) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            sig_q     <= 1'b0;
            wd_q      <= '0;
            fatal_q   <= 1'b0;
            fis_cnt_q <= '0;
            err_cnt_q <= '0;
            done_q    <= '0;
            crc_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            sig_q     <= sig_d;
            wd_q      <= wd_d;
            fatal_q   <= fatal_d;
            fis_cnt_q <= fis_cnt_d;
            err_cnt_q <= err_cnt_d;
            done_q    <= done_d;
            crc_q     <= crc_d;
            to_q      <= to_d;
        end
    end

    assign done_d2h     = done_q[D_D2H];
    assign done_sdb     = done_q[D_SDB];
    assign done_ds      = done_q[D_DS];
    assign done_ps      = done_q[D_PS];
    assign done_sig     = done_q[D_SIG];
    assign done_data    = done_q[D_DATA];
    assign done_dma_act = done_q[D_DMA];
    assign fis_crc_err  = crc_q;
    assign fis_timeout  = to_q;
    assign fatal        = fatal_q;
    assign busy         = (state_q != S_IDLE);
    assign fis_count    = fis_cnt_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_ahci_fis_dispatch.sv
// Self-checking bench for ahci_fis_dispatch (TIMEOUT_BITS=4): directed and
// randomized FIS sequences against a rule-level reference model.
module tb_ahci_fis_dispatch;

    localparam int WD_LIMIT = 15;

    localparam int OC_OK   = 0;
    localparam int OC_CRC  = 1;
    localparam int OC_HANG = 2;
    localparam int OC_FERR = 3;

    localparam logic [7:0] G_SIG  = 8'h80;
    localparam logic [7:0] G_DS   = 8'h40;
    localparam logic [7:0] G_PS   = 8'h20;
    localparam logic [7:0] G_RFIS = 8'h10;
    localparam logic [7:0] G_SDB  = 8'h08;
    localparam logic [7:0] G_UFIS = 8'h04;
    localparam logic [7:0] G_DATA = 8'h02;
    localparam logic [7:0] G_IGN  = 8'h01;

    logic        mclk;
    logic        hba_rst_n;
    logic        fis_rx_en;
    logic        sig_pending;
    logic        done_d2h, done_sdb, done_ds, done_ps;
    logic        done_sig, done_data, done_dma_act;
    logic        fis_crc_err, fis_timeout, fatal, busy;
    logic [15:0] fis_count;
    logic [7:0]  err_count;

    ahci_fis_dispatch_if eng ();

    ahci_fis_dispatch #(.TIMEOUT_BITS(4)) dut (
        .mclk         (mclk),
        .hba_rst_n    (hba_rst_n),
        .eng          (eng),
        .fis_rx_en    (fis_rx_en),
        .sig_pending  (sig_pending),
        .done_d2h     (done_d2h),
        .done_sdb     (done_sdb),
        .done_ds      (done_ds),
        .done_ps      (done_ps),
        .done_sig     (done_sig),
        .done_data    (done_data),
        .done_dma_act (done_dma_act),
        .fis_crc_err  (fis_crc_err),
        .fis_timeout  (fis_timeout),
        .fatal        (fatal),
        .busy         (busy),
        .fis_count    (fis_count),
        .err_count    (err_count)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_chk = 0;
    int n_err = 0;
    int m_fis = 0;
    int m_err = 0;

    logic [7:0] getv;
    logic [6:0] donev;
    assign getv = {eng.get_sig, eng.get_dsfis, eng.get_psfis, eng.get_rfis,
                   eng.get_sdbfis, eng.get_ufis, eng.get_data_fis,
                   eng.get_ignore};
    assign donev = {done_d2h, done_sdb, done_ds, done_ps,
                    done_sig, done_data, done_dma_act};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Which request the engine should see, from the dispatch rules.
    function automatic logic [7:0] model_get(input logic [7:0] t,
                                             input bit sig, input bit rx);
        if (t == 8'h46) return G_DATA;
        if (t == 8'h39) return G_IGN;
        if (t == 8'h34 && sig) return G_SIG;
        if (!rx) return G_IGN;
        if (t == 8'h34) return G_RFIS;
        if (t == 8'hA1) return G_SDB;
        if (t == 8'h41) return G_DS;
        if (t == 8'h5F) return G_PS;
        return G_UFIS;
    endfunction

    // Which done pulse an OK completion of this type produces.
    function automatic logic [6:0] model_done(input logic [7:0] t,
                                              input bit sig);
        if (t == 8'h34) return sig ? 7'h04 : 7'h40;
        if (t == 8'hA1) return 7'h20;
        if (t == 8'h41) return 7'h10;
        if (t == 8'h5F) return 7'h08;
        if (t == 8'h46) return 7'h02;
        if (t == 8'h39) return 7'h01;
        return 7'h00;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_get"}, getv, 0);
        check({tag, "_done"}, donev, 0);
        check({tag, "_crc"}, fis_crc_err, 0);
        check({tag, "_to"}, fis_timeout, 0);
        check({tag, "_fatal"}, fatal, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fcnt"}, fis_count, 0);
        check({tag, "_ecnt"}, err_count, 0);
    endtask

    // Runs one FIS starting at a negedge in IDLE; engine completes with
    // outcome oc during WAIT cycle len (1-based) unless the watchdog wins.
    task automatic run_fis(input logic [7:0] t, input bit sig, input bit rx,
                           input int len, input int oc);
        int e;
        logic [6:0] dexp;
        bit crc_exp, to_exp, fat_exp;
        eng.fis_type      = t;
        eng.fis_first_vld = 1'b1;
        sig_pending       = sig;
        fis_rx_en         = rx;
        @(negedge mclk);
        check("get_issue", getv, model_get(t, sig, rx));
        check("busy_issue", busy, 1);
        eng.fis_first_vld = 1'b0;
        eng.get_fis_busy  = 1'b1;
        if (oc == OC_FERR) e = len;
        else if (oc != OC_HANG && len <= WD_LIMIT) e = len;
        else e = WD_LIMIT;
        for (int k = 1; k <= e; k++) begin
            @(negedge mclk);
            check("get_wait", getv, 0);
            check("busy_wait", busy, 1);
            sig_pending       = 1'($urandom);
            fis_rx_en         = 1'($urandom);
            eng.fis_type      = 8'($urandom);
            eng.fis_first_vld = (k < e) ? 1'($urandom) : 1'b0;
            if (k == len) begin
                if (oc == OC_OK) begin
                    eng.get_fis_busy = 1'b0;
                    eng.fis_ok       = 1'b1;
                end else if (oc == OC_CRC) begin
                    eng.get_fis_busy = 1'b0;
                    eng.fis_err      = 1'b1;
                end else if (oc == OC_FERR) begin
                    eng.fis_ferr = 1'b1;
                end
            end
        end
        @(negedge mclk);
        dexp = '0; crc_exp = 0; to_exp = 0; fat_exp = 0;
        if (oc == OC_FERR) begin
            fat_exp = 1;
        end else if (oc == OC_OK && len <= WD_LIMIT) begin
            dexp = model_done(t, sig);
            if (m_fis < 65535) m_fis++;
        end else if (oc == OC_CRC && len <= WD_LIMIT) begin
            crc_exp = 1;
            if (m_err < 255) m_err++;
        end else begin
            to_exp = 1;
            if (m_err < 255) m_err++;
        end
        check("done", donev, dexp);
        check("crc", fis_crc_err, crc_exp);
        check("timeout", fis_timeout, to_exp);
        check("fatal", fatal, fat_exp);
        check("busy_end", busy, fat_exp);
        check("fis_count", fis_count, m_fis);
        check("err_count", err_count, m_err);
        eng.fis_ok       = 1'b0;
        eng.fis_err      = 1'b0;
        eng.get_fis_busy = 1'b0;
    endtask

    logic [7:0] tlist [8];
    int oc;

    initial begin
        tlist[0] = 8'h34; tlist[1] = 8'hA1; tlist[2] = 8'h41;
        tlist[3] = 8'h5F; tlist[4] = 8'h46; tlist[5] = 8'h39;
        tlist[6] = 8'h27; tlist[7] = 8'h00;
        hba_rst_n         = 1'b0;
        fis_rx_en         = 1'b1;
        sig_pending       = 1'b0;
        eng.fis_first_vld = 1'b0;
        eng.fis_type      = 8'h00;
        eng.get_fis_busy  = 1'b0;
        eng.fis_ok        = 1'b0;
        eng.fis_err       = 1'b0;
        eng.fis_ferr      = 1'b0;
        repeat (3) @(negedge mclk);
        check_idle_zero("rst");
        hba_rst_n = 1'b1;
        @(negedge mclk);
        check_idle_zero("post_rst");

        // D2H as signature, then as ordinary register FIS
        run_fis(8'h34, 1, 1, 6, OC_OK);
        run_fis(8'h34, 0, 1, 6, OC_OK);
        // FRE off: ignored but still completed
        run_fis(8'hA1, 0, 0, 3, OC_OK);
        run_fis(8'h41, 0, 0, 4, OC_OK);
        run_fis(8'h5F, 0, 0, 2, OC_OK);
        run_fis(8'h27, 0, 0, 5, OC_OK);
        // data FIS forwarded regardless of FRE
        run_fis(8'h46, 0, 0, 4, OC_OK);
        run_fis(8'h39, 1, 1, 3, OC_OK);
        // CRC error
        run_fis(8'hA1, 0, 1, 3, OC_CRC);
        // watchdog: hung engine, then completion on the expiry cycle
        run_fis(8'h41, 0, 1, 0, OC_HANG);
        run_fis(8'h5F, 0, 1, WD_LIMIT, OC_OK);
        run_fis(8'hA1, 0, 1, WD_LIMIT + 1, OC_OK);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] t;
            t = tlist[$urandom_range(0, 7)];
            if (t == 8'h00) t = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       oc = OC_HANG;
                1, 2:    oc = OC_CRC;
                default: oc = OC_OK;
            endcase
            run_fis(t, 1'($urandom), 1'($urandom),
                    $urandom_range(2, 17), oc);
        end

        // error counter saturation
        while (m_err < 255)
            run_fis(8'hA1, 0, 1, 2, OC_CRC);
        repeat (4) run_fis(8'hA1, 0, 1, 2, OC_CRC);
        run_fis(8'h41, 0, 1, 0, OC_HANG);

        // fatal: absorbing, no further requests
        run_fis(8'h46, 0, 1, 4, OC_FERR);
        for (int i = 0; i < 6; i++) begin
            eng.fis_first_vld = 1'b1;
            eng.fis_type      = tlist[i];
            fis_rx_en         = 1'b1;
            @(negedge mclk);
            check("fatal_get", getv, 0);
            check("fatal_busy", busy, 1);
            check("fatal_flag", fatal, 1);
        end
        eng.fis_first_vld = 1'b0;
        eng.fis_ferr      = 1'b0;
        hba_rst_n         = 1'b0;
        #1;
        m_fis = 0;
        m_err = 0;
        check_idle_zero("rst2");
        @(negedge mclk);
        hba_rst_n = 1'b1;
        @(negedge mclk);
        check_idle_zero("post_rst2");
        run_fis(8'hA1, 0, 1, 3, OC_OK);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
